// File: rtl/crossing_arbiter.sv
// Round-robin arbiter for a single shared track crossing: grants one train at a time,
// steers the crossing switch, revokes unused grants and enforces a guard gap.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | crossing free; arbitrates pending requests round-robin
// GRANT    | one train granted, waiting for its entry sensor (timed)
// OCCUPIED | granted train is inside the crossing, waiting for exit_s
// CLEAR    | grant dropped; guard interval before the next arbitration
module crossing_arbiter #(
  parameter int N        = 4,
  parameter int IW       = 2,
  parameter int ENTER_TO = 8,
  parameter int GUARD    = 2,
  parameter int TW       = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic [N-1:0]  enter,
  input  logic          exit_s,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] sw_sel,
  output logic          busy,
  output logic          timeout_err,
  output logic          intrusion_err
);

  typedef enum logic [1:0] {IDLE, GRANT, OCCUPIED, CLEAR} state_t;

  localparam logic [TW-1:0] ENTER_LOAD = TW'(ENTER_TO - 1);
  localparam logic [TW-1:0] GUARD_LOAD = TW'(GUARD - 1);

  state_t        state, state_nxt;
  logic [IW-1:0] ptr, ptr_nxt;
  logic [IW-1:0] sw_sel_nxt;
  logic [IW-1:0] pick;
  logic [IW-1:0] after_sel;
  logic          found;
  logic [TW-1:0] timer, timer_nxt;
  logic [N-1:0]  grant_nxt;
  logic          busy_nxt;
  logic          timeout_nxt;
  logic          intrusion_nxt;

  function automatic logic [IW-1:0] wrap_add(input int base, input int off);
    return IW'((base + off) % N);
  endfunction

  // First requester at or after ptr, wrapping around.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && req[wrap_add(int'(ptr), i)]) begin
        found = 1'b1;
        pick  = wrap_add(int'(ptr), i);
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    grant_nxt   = grant;
    sw_sel_nxt  = sw_sel;
    busy_nxt    = busy;
    timer_nxt   = timer;
    ptr_nxt     = ptr;
    timeout_nxt = 1'b0;
    after_sel   = wrap_add(int'(sw_sel), 1);
    // grant is the holder's one-hot in GRANT/OCCUPIED and zero elsewhere,
    // so masking it off flags every entry that is not the legitimate one.
    intrusion_nxt = |(enter & ~grant);

    case (state)
      IDLE: begin
        grant_nxt = '0;
        busy_nxt  = 1'b0;
        if (found) begin
          state_nxt       = GRANT;
          grant_nxt[pick] = 1'b1;
          sw_sel_nxt      = pick;
          busy_nxt        = 1'b1;
          timer_nxt       = ENTER_LOAD;
        end
      end
      GRANT: begin
        if (enter[sw_sel]) begin
          state_nxt = OCCUPIED;
        end else if (!req[sw_sel] || timer == '0) begin
          state_nxt   = CLEAR;
          grant_nxt   = '0;
          timer_nxt   = GUARD_LOAD;
          ptr_nxt     = after_sel;
          timeout_nxt = req[sw_sel];
        end else begin
          timer_nxt = timer - TW'(1);
        end
      end
      OCCUPIED: begin
        if (exit_s) begin
          state_nxt = CLEAR;
          grant_nxt = '0;
          timer_nxt = GUARD_LOAD;
          ptr_nxt   = after_sel;
        end
      end
      CLEAR: begin
        grant_nxt = '0;
        if (timer == '0) begin
          state_nxt = IDLE;
          busy_nxt  = 1'b0;
        end else begin
          timer_nxt = timer - TW'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        grant_nxt = '0;
        busy_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      grant         <= '0;
      sw_sel        <= '0;
      busy          <= 1'b0;
      timeout_err   <= 1'b0;
      intrusion_err <= 1'b0;
      ptr           <= '0;
      timer         <= '0;
    end else begin
      state         <= state_nxt;
      grant         <= grant_nxt;
      sw_sel        <= sw_sel_nxt;
      busy          <= busy_nxt;
      timeout_err   <= timeout_nxt;
      intrusion_err <= intrusion_nxt;
      ptr           <= ptr_nxt;
      timer         <= timer_nxt;
    end
  end

endmodule

// File: doc/crossing_arbiter.md
Name: crossing_arbiter

Overview:
- Arbitrates a single shared track crossing between N trains, using approach, entry and exit sensors.
- Grants the crossing to one train at a time with round-robin fairness and drives the crossing switch to that train's route.
- Revokes a grant that goes unused past a timeout and enforces a guard interval before the next grant.
- Sits beside the per-loop train controllers; each controller treats its grant bit as "proceed through crossing".

Parameters:
- N, 4, number of requesting trains/routes (2..8).
- IW, 2, width of route index (ceil(log2(N))).
- ENTER_TO, 8, cycles a granted train has to assert its entry sensor.
- GUARD, 2, clear-interval cycles after release before the next grant (>=1).
- TW, 8, timer width; must hold max(ENTER_TO, GUARD).

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous reset, active-high
- req  in  N  approach sensors, level; bit i = train i waiting at crossing
- enter  in  N  entry sensors, bit i = train i entering crossing
- exit_s  in  1  crossing exit sensor (shared)
- grant  out  N  one-hot (or zero) permission to enter
- sw_sel  out  IW  crossing switch route index
- busy  out  1  crossing reserved (GRANT/OCCUPIED/CLEAR)
- timeout_err  out  1  one-cycle pulse: grant revoked unused
- intrusion_err  out  1  one-cycle pulse: unexpected entry

Behaviour:
- One clock; reset is synchronous and active-high. All outputs registered.
- Reset (rst=1 at an edge, any state, including mid-operation):
  - state=IDLE; grant=0; sw_sel=0; busy=0; timeout_err=0; intrusion_err=0.
  - Round-robin pointer ptr=0; timer=0.
- States: IDLE, GRANT, OCCUPIED, CLEAR.
- IDLE:
  - If req!=0, select the first set bit scanning ptr, ptr+1, ... wrapping mod N. Its index is idx.
  - Next edge: grant=onehot(idx), sw_sel=idx, busy=1, timer=0, state=GRANT.
  - Latency: req sampled at edge t gives grant visible after edge t+1.
- GRANT:
  - enter[idx]=1 -> OCCUPIED; grant held.
  - Else if req[idx]=0 (train withdrew) -> grant=0, CLEAR, no error.
  - Else if timer==ENTER_TO-1 -> grant=0, timeout_err=1 for one cycle, CLEAR.
  - Else timer+1.
  - Precedence within GRANT: enter over withdraw, withdraw over timeout.
- OCCUPIED:
  - Grant held; waits for exit_s=1.
  - On exit_s: grant=0, state=CLEAR.
  - If exit_s and enter[idx] are asserted in the same cycle, exit wins.
- CLEAR:
  - grant=0, busy=1, sw_sel held. Timer counts GUARD cycles, then state=IDLE with busy=0.
  - IDLE re-arbitrates on the first edge in IDLE.
- ptr update: on every exit from GRANT/OCCUPIED to CLEAR, ptr=(idx+1) mod N. This applies to normal release, withdraw and timeout.
- intrusion_err: one-cycle pulse when either of these holds; state and grant are unaffected.
  - enter[j]=1 for any j!=idx.
  - enter[idx]=1 while in any state other than GRANT/OCCUPIED.
  - Consequence: in IDLE, any enter bit raises it.
- exit_s outside OCCUPIED is ignored.
- sw_sel changes only on IDLE->GRANT; it is stable while a train is granted or in the crossing.
- At most one grant bit is ever set. grant!=0 implies busy=1.

Test Plan:
- Reset/idle: rst=1 for 2 cycles with req=4'b1111 -> grant=0, busy=0, sw_sel=0. Release rst -> grant=4'b0001 one edge later, sw_sel=0.
- Normal pass: req[2]=1, enter[2] pulse 3 cycles after grant, exit_s pulse 4 cycles later:
  - grant=4'b0100 and sw_sel=2 until the exit edge, then grant=0.
  - busy drops after 2 CLEAR cycles.
  - ptr=3.
- Round-robin: req=4'b1011 held, each grantee enters/exits promptly -> grant order 0,1,3,0 with GUARD=2 gaps of grant=0 between grants.
- Timeout: req[1]=1, no enter -> grant=4'b0010 for exactly 8 cycles, then timeout_err high 1 cycle, grant=0. With req=4'b0011 both held, the next grant is train 0 after 2 guard cycles.
- Errors/precedence:
  - enter[3] while train 1 is granted -> intrusion_err 1 cycle, grant unchanged.
  - Same-cycle enter[1] and exit_s in OCCUPIED -> CLEAR taken.
  - Enter on the timeout cycle -> OCCUPIED, no timeout_err.
- Reset mid-operation: rst=1 in OCCUPIED -> next edge grant=0, busy=0, ptr=0. With req=4'b0100 held, grant=4'b0100 on the first edge after rst=0.
